// File: rtl/nios2_oci_pkg.sv
// State encoding and jdo field positions shared by the OCI memory arbiter and its sub-module.
package nios2_oci_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        J_ACC = 3'd1,
        J_RD  = 3'd2,
        A_ACC = 3'd3,
        A_RD  = 3'd4
    } ociState_t;

    localparam int JDO_W       = 38;
    localparam int JDO_ADDR_HI = 33;
    localparam int JDO_ADDR_LO = 26;
    localparam int JDO_RD      = 35;
    localparam int JDO_ERRCLR  = 25;
    localparam int JDO_WD_HI   = 34;
    localparam int JDO_WD_LO   = 3;

    localparam logic       RR_JTAG    = 1'b0;
    localparam logic       RR_AV      = 1'b1;
    localparam logic [3:0] BYTEEN_ALL = 4'hF;

endpackage

// File: rtl/nios2_oci_rr_arb2.sv
// Two-way round-robin arbiter: request/grant bit 0 is JTAG, bit 1 is the Avalon slave.
module nios2_oci_rr_arb2
    import nios2_oci_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_enable,
    output logic [1:0] o_grant
);

    logic r_rrLast;

    // On contention the requester that did not win last time gets the port.
    always_comb begin
        o_grant = 2'b00;
        if (i_enable) begin
            case (i_req)
                2'b01:   o_grant = 2'b01;
                2'b10:   o_grant = 2'b10;
                2'b11:   o_grant = (r_rrLast == RR_AV) ? 2'b01 : 2'b10;
                default: o_grant = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rrLast <= RR_AV;
        end else if (o_grant[0]) begin
            r_rrLast <= RR_JTAG;
        end else if (o_grant[1]) begin
            r_rrLast <= RR_AV;
        end
    end

endmodule

// File: rtl/nios2_ocimem_access_arbiter.sv
// Owns the OCI debug RAM port, sharing it between decoded JTAG commands and the CPU debug slave.
module nios2_ocimem_access_arbiter
    import nios2_oci_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [DATA_W-1:0] av_writedata,
    input  logic [3:0]        av_byteenable,
    output logic [DATA_W-1:0] av_readdata,
    output logic              av_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [3:0]        ram_byteen,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    ociState_t         r_state;
    ociState_t         w_nextState;
    logic [ADDR_W-1:0] r_monAReg;
    logic [DATA_W-1:0] r_monDReg;
    logic [DATA_W-1:0] r_avRdata;
    logic              r_jpend;
    logic              r_jWrite;
    logic              r_monReady;
    logic              r_monError;
    logic              w_anyStrobe;
    logic              w_accept;
    logic              w_drop;
    logic              w_queue;
    logic              w_setError;
    logic              w_clrError;
    logic              w_jDone;
    logic              w_wrStrobe;
    logic [1:0]        w_req;
    logic [1:0]        w_grant;
    logic              w_unusedJdoBits;

    assign w_unusedJdoBits = ^{jdo[37:36], jdo[2:0]};

    // Strobe a outranks b, so a write strobe only counts when a is absent.
    assign w_anyStrobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign w_wrStrobe  = ~take_action_ocimem_a & take_action_ocimem_b;
    assign w_drop      = w_anyStrobe & r_jpend;
    assign w_accept    = w_anyStrobe & ~r_jpend;
    assign w_queue     = w_accept & (take_action_ocimem_a ? jdo[JDO_RD] : 1'b1);
    assign w_setError  = w_drop | (take_action_ocimem_a & take_action_ocimem_b);
    assign w_clrError  = w_accept & take_action_ocimem_a & jdo[JDO_ERRCLR];
    assign w_jDone     = ((r_state == J_ACC) && r_jWrite) || (r_state == J_RD);

    assign w_req = {av_read | av_write, r_jpend};

    nios2_oci_rr_arb2 u_rrArb (
        .clk      (clk),
        .reset    (reset),
        .i_req    (w_req),
        .i_enable (r_state == IDLE),
        .o_grant  (w_grant)
    );

    // Acceptance needs jpend low and completion needs it high, so the two never coincide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_jpend    <= 1'b0;
            r_jWrite   <= 1'b0;
            r_monReady <= 1'b1;
            r_monError <= 1'b0;
            r_monAReg  <= '0;
            r_monDReg  <= '0;
        end else begin
            if (w_jDone) begin
                r_jpend    <= 1'b0;
                r_monReady <= 1'b1;
                r_monAReg  <= r_monAReg + 1'b1;
                if (r_state == J_RD) begin
                    r_monDReg <= ram_rdata;
                end
            end else if (w_accept) begin
                if (take_action_ocimem_a) begin
                    r_monAReg <= ADDR_W'(jdo[JDO_ADDR_HI:JDO_ADDR_LO]);
                end
                if (w_wrStrobe) begin
                    r_monDReg <= DATA_W'(jdo[JDO_WD_HI:JDO_WD_LO]);
                end
                if (w_queue) begin
                    r_jpend    <= 1'b1;
                    r_monReady <= 1'b0;
                    r_jWrite   <= w_wrStrobe;
                end
            end
            if (w_setError) begin
                r_monError <= 1'b1;
            end else if (w_clrError) begin
                r_monError <= 1'b0;
            end
        end
    end

    always_comb begin
        w_nextState = IDLE;
        case (r_state)
            IDLE: begin
                if (w_grant[0]) begin
                    w_nextState = J_ACC;
                end else if (w_grant[1]) begin
                    w_nextState = A_ACC;
                end
            end
            J_ACC:   w_nextState = r_jWrite ? IDLE : J_RD;
            A_ACC:   w_nextState = av_write ? IDLE : A_RD;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_avRdata <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == A_RD) begin
                r_avRdata <= ram_rdata;
            end
        end
    end

    // RAM strobes come straight from the state so a reset removes them without waiting for a clock.
    always_comb begin
        ram_addr       = '0;
        ram_wren       = 1'b0;
        ram_byteen     = '0;
        ram_wdata      = '0;
        av_waitrequest = 1'b1;
        case (r_state)
            J_ACC: begin
                ram_addr   = r_monAReg;
                ram_wren   = r_jWrite;
                ram_byteen = BYTEEN_ALL;
                ram_wdata  = r_monDReg;
            end
            A_ACC: begin
                ram_addr       = av_address;
                ram_wren       = av_write;
                ram_byteen     = av_byteenable;
                ram_wdata      = av_writedata;
                av_waitrequest = ~av_write;
            end
            A_RD: begin
                av_waitrequest = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // The RAM output is already registered, so it is valid during the completing cycle and held afterwards.
    assign av_readdata   = (r_state == A_RD) ? ram_rdata : r_avRdata;
    assign MonDReg       = r_monDReg;
    assign monitor_ready = r_monReady;
    assign monitor_error = r_monError;

endmodule

// File: tb/tb_nios2_ocimem_access_arbiter.sv
// Self-checking bench for the OCI memory arbiter with a behavioural 256x32 RAM and read scoreboards.
module tb_nios2_ocimem_access_arbiter;
    import nios2_oci_pkg::*;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] pre;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] exp;
    } avVec_t;

    logic        clock;
    logic        reset;
    logic [37:0] jdo;
    logic        takeA;
    logic        takeB;
    logic        takeNoA;
    logic [7:0]  avAddress;
    logic        avRead;
    logic        avWrite;
    logic [31:0] avWritedata;
    logic [3:0]  avByteenable;
    logic [31:0] avReaddata;
    logic        avWaitrequest;
    logic [7:0]  ramAddr;
    logic        ramWren;
    logic [3:0]  ramByteen;
    logic [31:0] ramWdata;
    logic [31:0] ramRdata;
    logic [31:0] monDReg;
    logic        monitorReady;
    logic        monitorError;

    logic        preEn;
    logic [7:0]  preAddr;
    logic [31:0] preData;
    logic [31:0] ram [256];

    logic [31:0] expAvQ [$];
    logic [31:0] expJQ [$];
    avVec_t      vecs [5];
    int          checks;
    int          failures;

    nios2_ocimem_access_arbiter dut (
        .clk                     (clock),
        .reset                   (reset),
        .jdo                     (jdo),
        .take_action_ocimem_a    (takeA),
        .take_action_ocimem_b    (takeB),
        .take_no_action_ocimem_a (takeNoA),
        .av_address              (avAddress),
        .av_read                 (avRead),
        .av_write                (avWrite),
        .av_writedata            (avWritedata),
        .av_byteenable           (avByteenable),
        .av_readdata             (avReaddata),
        .av_waitrequest          (avWaitrequest),
        .ram_addr                (ramAddr),
        .ram_wren                (ramWren),
        .ram_byteen              (ramByteen),
        .ram_wdata               (ramWdata),
        .ram_rdata               (ramRdata),
        .MonDReg                 (monDReg),
        .monitor_ready           (monitorReady),
        .monitor_error           (monitorError)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural RAM: registered read, byte-enabled write, plus a bench-only preload port.
    always @(posedge clock) begin
        if (preEn) begin
            ram[preAddr] <= preData;
        end else if (ramWren) begin
            for (int i = 0; i < 4; i++) begin
                if (ramByteen[i]) ram[ramAddr][8*i +: 8] <= ramWdata[8*i +: 8];
            end
        end
        ramRdata <= ram[ramAddr];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Avalon read completions are matched in order against the expected-data queue.
    always @(negedge clock) begin
        if (!reset && avRead && !avWaitrequest) begin
            if (expAvQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL avUnexpectedRead: got %h, expected no completion", avReaddata);
            end else begin
                checkOutput("avReaddata", avReaddata, expAvQ.pop_front());
            end
        end
    end

    function automatic logic [37:0] jdoA(input logic rd, input logic errClr, input logic [7:0] addr);
        logic [37:0] d;
        d = '0;
        d[JDO_RD] = rd;
        d[JDO_ERRCLR] = errClr;
        d[JDO_ADDR_HI:JDO_ADDR_LO] = addr;
        return d;
    endfunction

    function automatic logic [37:0] jdoB(input logic [31:0] wd);
        logic [37:0] d;
        d = '0;
        d[JDO_WD_HI:JDO_WD_LO] = wd;
        return d;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic preload(input logic [7:0] addr, input logic [31:0] data);
        preEn = 1'b1;
        preAddr = addr;
        preData = data;
        tick();
        preEn = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        jdo = '0;
        takeA = 1'b0;
        takeB = 1'b0;
        takeNoA = 1'b0;
        avAddress = '0;
        avRead = 1'b0;
        avWrite = 1'b0;
        avWritedata = '0;
        avByteenable = '0;
        preEn = 1'b0;
        preAddr = '0;
        preData = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic jtagStrobe(input logic a, input logic b, input logic na, input logic [37:0] d);
        takeA = a;
        takeB = b;
        takeNoA = na;
        jdo = d;
        tick();
        takeA = 1'b0;
        takeB = 1'b0;
        takeNoA = 1'b0;
        jdo = '0;
    endtask

    task automatic waitReady(input string name);
        int cnt;
        cnt = 0;
        while (!monitorReady && cnt < 30) begin
            tick();
            cnt++;
        end
        checkOutput({name, "_ready"}, 32'(monitorReady), 32'd1);
    endtask

    task automatic jtagAccess(input logic a, input logic b, input logic na, input logic [37:0] d,
                              input bit isRead, input logic [31:0] expData, input int expLat,
                              input string name);
        int lat;
        if (isRead) expJQ.push_back(expData);
        jtagStrobe(a, b, na, d);
        lat = 0;
        while (!monitorReady && lat < 30) begin
            tick();
            lat++;
        end
        if (!monitorReady) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_timeout: got ready=0, expected ready=1", name);
            if (isRead && expJQ.size() > 0) void'(expJQ.pop_back());
        end else begin
            checkOutput({name, "_latency"}, 32'(lat), 32'(expLat));
            if (isRead) checkOutput({name, "_MonDReg"}, monDReg, expJQ.pop_front());
        end
    endtask

    task automatic avAccess(input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                            input logic [3:0] be, input logic [31:0] expRd, input int expCycles,
                            input string name);
        int lat;
        if (!wr) expAvQ.push_back(expRd);
        avAddress = addr;
        avWritedata = wd;
        avByteenable = be;
        avWrite = wr;
        avRead = !wr;
        lat = 0;
        while (avWaitrequest && lat < 30) begin
            tick();
            lat++;
        end
        if (avWaitrequest) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_timeout: got waitrequest=1, expected completion", name);
            if (!wr && expAvQ.size() > 0) void'(expAvQ.pop_back());
        end else begin
            checkOutput({name, "_cycles"}, 32'(lat + 1), 32'(expCycles));
        end
        tick();
        avRead = 1'b0;
        avWrite = 1'b0;
        checkOutput({name, "_waitIdle"}, 32'(avWaitrequest), 32'd1);
    endtask

    task automatic applyStimulus(input avVec_t v);
        preload(v.addr, v.pre);
        avAccess(1'b1, v.addr, v.wd, v.be, '0, 2, "avWr");
        checkOutput("avRamMerge", ram[v.addr], v.exp);
        avAccess(1'b0, v.addr, '0, 4'h0, v.exp, 3, "avRd");
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        checks = 0;
        failures = 0;
        vecs[0] = '{8'h05, 32'h11223344, 4'b0010, 32'h0000AB00, 32'h1122AB44};
        vecs[1] = '{8'h06, 32'hAABBCCDD, 4'b1111, 32'h01234567, 32'h01234567};
        vecs[2] = '{8'h07, 32'hAABBCCDD, 4'b1001, 32'h11223344, 32'h11BBCC44};
        vecs[3] = '{8'h08, 32'h00000000, 4'b0000, 32'hFFFFFFFF, 32'h00000000};
        vecs[4] = '{8'hFF, 32'h12345678, 4'b0100, 32'h00EE0000, 32'h12EE5678};

        doReset();
        checkOutput("rstWaitrequest", 32'(avWaitrequest), 32'd1);
        checkOutput("rstReady", 32'(monitorReady), 32'd1);
        checkOutput("rstError", 32'(monitorError), 32'd0);
        checkOutput("rstWren", 32'(ramWren), 32'd0);
        checkOutput("rstMonDReg", monDReg, 32'd0);
        checkOutput("rstReaddata", avReaddata, 32'd0);
        checkOutput("rstRamAddr", 32'(ramAddr), 32'd0);

        // JTAG write at 0x10 then streaming reads from the incremented address.
        preload(8'h11, 32'hCAFEF00D);
        preload(8'h12, 32'h12121212);
        jtagStrobe(1'b1, 1'b0, 1'b0, jdoA(1'b0, 1'b0, 8'h10));
        checkOutput("addrLoadReady", 32'(monitorReady), 32'd1);
        jtagAccess(1'b0, 1'b1, 1'b0, jdoB(32'hDEADBEEF), 1'b0, '0, 2, "jWr10");
        checkOutput("ram10", ram[8'h10], 32'hDEADBEEF);
        jtagAccess(1'b0, 1'b0, 1'b1, '0, 1'b1, 32'hCAFEF00D, 3, "jStream11");
        jtagAccess(1'b1, 1'b0, 1'b0, jdoA(1'b1, 1'b0, 8'h10), 1'b1, 32'hDEADBEEF, 3, "jRd10");
        jtagAccess(1'b0, 1'b0, 1'b1, '0, 1'b1, 32'hCAFEF00D, 3, "jStream11b");
        jtagAccess(1'b0, 1'b0, 1'b1, '0, 1'b1, 32'h12121212, 3, "jStream12");

        // Contention with rr_last=AV: JTAG goes first and Avalon sees the fresh data.
        doReset();
        preload(8'h20, 32'h0);
        jtagStrobe(1'b1, 1'b0, 1'b0, jdoA(1'b0, 1'b0, 8'h20));
        takeB = 1'b1;
        jdo = jdoB(32'h5A5A1234);
        tick();
        takeB = 1'b0;
        jdo = '0;
        expAvQ.push_back(32'h5A5A1234);
        avAddress = 8'h20;
        avRead = 1'b1;
        lat = 0;
        while (avWaitrequest && lat < 30) begin
            tick();
            lat++;
        end
        checkOutput("rrJtagFirstCycles", 32'(lat), 32'd4);
        checkOutput("rrJtagFirstReady", 32'(monitorReady), 32'd1);
        tick();
        avRead = 1'b0;
        checkOutput("rrJtagFirstWaitIdle", 32'(avWaitrequest), 32'd1);

        // Contention with rr_last=JTAG: Avalon goes first and sees the old data.
        jtagAccess(1'b1, 1'b0, 1'b0, jdoA(1'b1, 1'b0, 8'h20), 1'b1, 32'h5A5A1234, 3, "jRd20");
        takeB = 1'b1;
        jdo = jdoB(32'h0BADCAFE);
        tick();
        takeB = 1'b0;
        jdo = '0;
        expAvQ.push_back(32'h5A5A1234);
        avAddress = 8'h20;
        avRead = 1'b1;
        lat = 0;
        while (avWaitrequest && lat < 30) begin
            tick();
            lat++;
        end
        checkOutput("rrAvFirstCycles", 32'(lat), 32'd2);
        checkOutput("rrAvFirstJPending", 32'(monitorReady), 32'd0);
        tick();
        avRead = 1'b0;
        waitReady("rrAvFirstJ");
        checkOutput("ram21", ram[8'h21], 32'h0BADCAFE);

        // Dropped strobes while a JTAG access is pending.
        jtagStrobe(1'b0, 1'b1, 1'b0, jdoB(32'h11111111));
        jtagStrobe(1'b0, 1'b1, 1'b0, jdoB(32'h22222222));
        checkOutput("dropError", 32'(monitorError), 32'd1);
        waitReady("dropW");
        checkOutput("dropRam22", ram[8'h22], 32'h11111111);
        checkOutput("dropMonDReg", monDReg, 32'h11111111);
        jtagStrobe(1'b0, 1'b1, 1'b0, jdoB(32'h33333333));
        jtagStrobe(1'b1, 1'b0, 1'b0, jdoA(1'b0, 1'b1, 8'h40));
        checkOutput("dropClrIgnored", 32'(monitorError), 32'd1);
        waitReady("dropA");
        checkOutput("dropRam23", ram[8'h23], 32'h33333333);
        preload(8'h24, 32'h24242424);
        jtagAccess(1'b0, 1'b0, 1'b1, '0, 1'b1, 32'h24242424, 3, "jStream24");
        jtagStrobe(1'b1, 1'b0, 1'b0, jdoA(1'b0, 1'b1, 8'h30));
        checkOutput("errClear", 32'(monitorError), 32'd0);

        // Coinciding a and b: a loads the address, b is ignored, error is flagged.
        preload(8'h50, 32'h50505050);
        jtagStrobe(1'b1, 1'b1, 1'b0, jdoA(1'b0, 1'b0, 8'h50));
        checkOutput("collideError", 32'(monitorError), 32'd1);
        checkOutput("collideReady", 32'(monitorReady), 32'd1);
        jtagAccess(1'b0, 1'b0, 1'b1, '0, 1'b1, 32'h50505050, 3, "jStream50");
        jtagStrobe(1'b1, 1'b0, 1'b0, jdoA(1'b0, 1'b1, 8'hFF));
        checkOutput("errClear2", 32'(monitorError), 32'd0);

        // MonAReg wraps from 0xFF to 0x00.
        preload(8'h00, 32'hA0A0A0A0);
        jtagAccess(1'b0, 1'b1, 1'b0, jdoB(32'hFFFF0001), 1'b0, '0, 2, "jWrFF");
        checkOutput("ramFF", ram[8'hFF], 32'hFFFF0001);
        jtagAccess(1'b0, 1'b0, 1'b1, '0, 1'b1, 32'hA0A0A0A0, 3, "jStreamWrap");

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i]);
        end

        // Reset in the middle of an Avalon read, then in the middle of an Avalon write.
        preload(8'h60, 32'h60606060);
        preload(8'h61, 32'h61616161);
        avAddress = 8'h60;
        avRead = 1'b1;
        tick();
        tick();
        checkOutput("preResetARd", 32'(avWaitrequest), 32'd0);
        reset = 1'b1;
        #1;
        checkOutput("midRdWaitrequest", 32'(avWaitrequest), 32'd1);
        checkOutput("midRdWren", 32'(ramWren), 32'd0);
        avRead = 1'b0;
        tick();
        reset = 1'b0;
        avAddress = 8'h61;
        avWritedata = 32'hFFFFFFFF;
        avByteenable = 4'hF;
        avWrite = 1'b1;
        tick();
        checkOutput("preResetAAccWren", 32'(ramWren), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("midWrWren", 32'(ramWren), 32'd0);
        avWrite = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        checkOutput("midWrRam61", ram[8'h61], 32'h61616161);
        avAccess(1'b0, 8'h60, '0, 4'h0, 32'h60606060, 3, "postResetRd");

        checkOutput("avQueueEmpty", 32'(expAvQ.size()), 32'd0);
        checkOutput("jQueueEmpty", 32'(expJQ.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
